svi_array_reader: RTL and testbench

- Reader and consumer end of an array of SVI stream instances; the counterpart to blocks that assign members of interface arrays.
- Samples SIZE instances of interface stream_if (members valid, data driven by writers; member ready driven here).
- Round-robin arbitrates between the instances and forwards one beat per cycle into a single registered output stream tagged with its source index.
- Sits in the top level between writer modules and a single downstream consumer; connection is by implicit `.*` on the interface array.

---
 rtl/svi_array_reader_pkg.sv | 19 +
 rtl/svi_array_reader_if.sv | 19 +
 rtl/svi_array_reader_rr_pick.sv | 31 +++
 rtl/svi_array_reader.sv | 76 +++++++
 tb/tb_svi_array_reader.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/svi_array_reader_pkg.sv
// Shared defaults and helpers for the SVI array reader.
package svi_pkg;

  localparam int SIZE_DEF   = 8;
  localparam int DATA_W_DEF = 8;

  // Index width for an array of n entries: clog2 with a floor of 1 bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment v (treated as a w-bit counter) but stop at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/svi_array_reader_if.sv
// Single valid/ready stream instance; an array of these feeds the reader.
//
// Handshake: a beat moves on a rising clock edge where valid && ready.
// ready may depend combinationally on valid; valid must never depend on
// ready, and a writer holds data stable while valid is high and unaccepted.
interface stream_if
  import svi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/svi_array_reader_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping from SIZE-1 back to 0.
module rr_pick
  import svi_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  localparam int IDX_W = idx_width(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan offsets from far to near so the nearest requester to ptr wins.
  always_comb begin
    int j;
    logic [IDX_W-1:0] j_idx;
    j       = 0;
    j_idx   = '0;
    gnt_idx = '0;
    any     = |req;
    for (int i = SIZE - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= SIZE) j = j - SIZE;
      j_idx = IDX_W'(j);
      if (req[j_idx]) gnt_idx = j_idx;
    end
  end

endmodule

// File: rtl/svi_array_reader.sv
// Consumer end of an array of stream_if instances: round-robin arbitration
// into one registered output stream tagged with the source index, plus a
// saturating count of accepted beats.
module svi_array_reader
  import svi_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16,
  localparam int IDX_W = idx_width(SIZE)
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  stream_if.slave           u_I [SIZE-1:0],
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_idx,
  output logic [CNT_W-1:0]  o_beats
);

  logic [SIZE-1:0]   req;
  logic [DATA_W-1:0] data_arr [SIZE];
  logic [SIZE-1:0]   ready_vec;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt;
  logic              any_valid;
  logic              load;
  logic              xfer;
  logic [IDX_W-1:0]  ptr_next;

  // Flatten the interface array into plain vectors for the picker and mux.
  for (genvar k = 0; k < SIZE; k++) begin : g_flat
    assign req[k]        = u_I[k].valid;
    assign data_arr[k]   = u_I[k].data;
    assign u_I[k].ready  = ready_vec[k];
  end

  rr_pick #(.SIZE(SIZE)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (gnt),
    .any     (any_valid)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign load     = !o_valid || i_ready;
  assign xfer     = i_arst_n && load && any_valid;
  assign ptr_next = (gnt == IDX_W'(SIZE - 1)) ? '0 : (gnt + IDX_W'(1));

  // One-hot ready to the granted instance; forced low while in reset.
  always_comb begin
    ready_vec = '0;
    if (xfer) ready_vec[gnt] = 1'b1;
  end

  // Output beat, source index, pointer and beat counter.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
      o_beats <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= data_arr[gnt];
      o_idx   <= gnt;
      ptr     <= ptr_next;
      o_beats <= CNT_W'(sat_inc(32'(o_beats), CNT_W));
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svi_array_reader.sv
// Directed bench for svi_array_reader with SIZE=8, DATA_W=8, CNT_W=16.
module tb_svi_array_reader;

  localparam int SIZE   = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  stream_if #(.DATA_W(DATA_W)) u_I [SIZE-1:0] ();

  logic              valid_t [SIZE];
  logic [DATA_W-1:0] data_t  [SIZE];
  logic [SIZE-1:0]   ready_vec;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [2:0]        o_idx;
  logic [CNT_W-1:0]  o_beats;

  for (genvar k = 0; k < SIZE; k++) begin : g_drv
    assign u_I[k].valid = valid_t[k];
    assign u_I[k].data  = data_t[k];
    assign ready_vec[k] = u_I[k].ready;
  end

  svi_array_reader #(.SIZE(SIZE), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .u_I      (u_I),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_beats  (o_beats)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valid();
    for (int k = 0; k < SIZE; k++) valid_t[k] = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [DATA_W-1:0] d);
    valid_t[k] = 1'b1;
    data_t[k]  = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < SIZE; k++) set_src(k, 8'(8'h10 + k));

    // Reset held with every source valid.
    repeat (3) tick();
    check("rst_ready", 32'(ready_vec), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_beats", 32'(o_beats), 32'h0);
    check("rst_idx",   32'(o_idx),   32'h0);
    check("rst_data",  32'(o_data),  32'h0);

    // Release; idx 0 is granted first, then strict rotation with no bubbles.
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(ready_vec), 32'h01);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_valid", 32'(o_valid), 32'h1);
      check("rr_idx",   32'(o_idx),   32'(i % 8));
      check("rr_data",  32'(o_data),  32'(8'h10 + (i % 8)));
    end
    check("rr_beats", 32'(o_beats), 32'd9);

    // Sources idle, downstream ready: output drains, payload holds.
    clear_valid();
    tick();
    check("drain_valid", 32'(o_valid), 32'h0);
    check("drain_data",  32'(o_data),  32'h10);

    // Single source 5.
    set_src(5, 8'hA5);
    #1;
    check("single_ready", 32'(ready_vec), 32'h20);
    tick();
    valid_t[5] = 1'b0;
    check("single_valid", 32'(o_valid), 32'h1);
    check("single_data",  32'(o_data),  32'hA5);
    check("single_idx",   32'(o_idx),   32'h5);
    check("single_beats", 32'(o_beats), 32'd10);

    // Backpressure: beat 0x33 from idx 2 stalls with source 3 waiting.
    set_src(2, 8'h33);
    tick();
    valid_t[2] = 1'b0;
    check("bp_load_idx", 32'(o_idx), 32'h2);
    set_src(3, 8'h44);
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready", 32'(ready_vec), 32'h0);
      tick();
      check("bp_data",  32'(o_data),  32'h33);
      check("bp_idx",   32'(o_idx),   32'h2);
      check("bp_valid", 32'(o_valid), 32'h1);
    end
    i_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(ready_vec), 32'h08);
    tick();
    valid_t[3] = 1'b0;
    check("bp_next_idx",  32'(o_idx),   32'h3);
    check("bp_next_data", 32'(o_data),  32'h44);
    check("bp_beats",     32'(o_beats), 32'd12);

    // Move ptr to 7 by granting source 6 alone.
    set_src(6, 8'h66);
    tick();
    check("ptr7_idx", 32'(o_idx), 32'h6);

    // Wrap and skip: only 1 and 6 valid, ptr=7 -> 1, 6, 1.
    set_src(1, 8'h61);
    tick();
    check("wrap_idx0", 32'(o_idx), 32'h1);
    check("wrap_dat0", 32'(o_data), 32'h61);
    tick();
    check("wrap_idx1", 32'(o_idx), 32'h6);
    tick();
    check("wrap_idx2", 32'(o_idx), 32'h1);
    check("wrap_beats", 32'(o_beats), 32'd16);
    clear_valid();
    tick();
    check("wrap_drain", 32'(o_valid), 32'h0);

    // Mid-transfer reset between edges.
    set_src(0, 8'h77);
    tick();
    check("mid_pre_valid", 32'(o_valid), 32'h1);
    check("mid_pre_beats", 32'(o_beats), 32'd17);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(o_valid), 32'h0);
    check("mid_beats", 32'(o_beats), 32'h0);
    check("mid_data",  32'(o_data),  32'h0);
    check("mid_ready", 32'(ready_vec), 32'h0);

    // Saturation: every source valid, run the counter to the top.
    for (int k = 0; k < SIZE; k++) set_src(k, 8'(8'h10 + k));
    tick();
    rst_n = 1'b1;
    repeat (65535) tick();
    check("sat_top", 32'(o_beats), 32'hFFFF);
    check("sat_top_idx", 32'(o_idx), 32'h6);
    tick();
    check("sat_hold", 32'(o_beats), 32'hFFFF);
    check("sat_hold_idx", 32'(o_idx), 32'h7);
    check("sat_hold_valid", 32'(o_valid), 32'h1);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
